// File: rtl/pj_bus_pkg.sv
// picoJava-II bus encodings shared by the bus slaves.
// Holds transaction type, size and ack codes plus the slave FSM states.
package pj_bus_pkg;

  localparam logic [3:0] TYPE_RD   = 4'b0000;
  localparam logic [3:0] TYPE_WR   = 4'b0001;
  localparam logic [3:0] TYPE_LINE = 4'b0100;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_OK   = 2'b01;
  localparam logic [1:0] ACK_ERR  = 2'b10;

  localparam int LINE_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACC,
    ST_RESP,
    ST_ERR
  } state_t;

endpackage

// File: rtl/pj_req_decode.sv
// Combinational request check and big-endian byte-lane decode.
// In: addr[29:0], typ[3:0], size[1:0]. Out: err, be[3:0], is_write, is_line.
module pj_req_decode
  import pj_bus_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [29:0] addr,
  input  logic [3:0]  typ,
  input  logic [1:0]  size,
  output logic        err,
  output logic [3:0]  be,
  output logic        is_write,
  output logic        is_line
);

  logic bad_type;
  logic bad_size;
  logic misalign;
  logic out_of_range;
  logic line_not_word;

  // Anything above the implemented word space is a decode miss.
  assign out_of_range = |(addr >> (AW + 2));

  always_comb begin
    is_write = 1'b0;
    is_line  = 1'b0;
    bad_type = 1'b0;
    unique case (typ)
      TYPE_RD:   bad_type = 1'b0;
      TYPE_WR:   is_write = 1'b1;
      TYPE_LINE: is_line  = 1'b1;
      default:   bad_type = 1'b1;
    endcase
  end

  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    bad_size = 1'b0;
    unique case (size)
      SIZE_BYTE: be = 4'b1000 >> addr[1:0];
      SIZE_HALF: begin
        misalign = addr[0];
        be       = addr[1] ? 4'b0011 : 4'b1100;
      end
      SIZE_WORD: begin
        misalign = |addr[1:0];
        be       = 4'b1111;
      end
      default:   bad_size = 1'b1;
    endcase
  end

  assign line_not_word = is_line && (size != SIZE_WORD);

  assign err = bad_type | bad_size | misalign
             | line_not_word | out_of_range;

endmodule

// File: rtl/pj_mem_slave.sv
// picoJava-II bus memory slave over a single-port synchronous SRAM.
// Bus: pj_addr/type/size/tv/ale/data_out in, pj_ack/pj_data_in out.
// SRAM: mem_cs/we/be/addr/wdata out, mem_rdata in (one-cycle latency).
module pj_mem_slave
  import pj_bus_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       pj_addr,
  input  logic [31:0]       pj_data_out,
  input  logic              pj_tv,
  input  logic              pj_ale,
  input  logic [3:0]        pj_type,
  input  logic [1:0]        pj_size,
  output logic [1:0]        pj_ack,
  output logic [31:0]       pj_data_in,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // The counter is loaded with W-1 so WAIT lasts exactly W cycles.
  localparam logic [3:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] LAST_BEAT = 2'(LINE_LEN - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [1:0]        beat;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              write_q;
  logic              line_q;

  logic              dec_err;
  logic [3:0]        dec_be;
  logic              dec_write;
  logic              dec_line;

  logic              issue;
  logic [1:0]        word_off;
  logic [1:0]        word_lo;
  logic [MEM_AW-1:0] word_addr;

  pj_req_decode #(
    .AW(MEM_AW)
  ) u_dec (
    .addr     (pj_addr),
    .typ      (pj_type),
    .size     (pj_size),
    .err      (dec_err),
    .be       (dec_be),
    .is_write (dec_write),
    .is_line  (dec_line)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      beat     <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      write_q  <= 1'b0;
      line_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat <= 2'd0;
          if (pj_tv && pj_ale) begin
            addr_q  <= pj_addr[MEM_AW+1:2];
            wdata_q <= pj_data_out;
            be_q    <= dec_be;
            write_q <= dec_write;
            line_q  <= dec_line;
            if (dec_err) begin
              state <= ST_ERR;
            end else if (WAIT_STATES == 0) begin
              state <= ST_ACC;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!pj_tv) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == 4'd0) begin
            state <= ST_ACC;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACC: begin
          state <= pj_tv ? ST_RESP : ST_IDLE;
        end
        ST_RESP: begin
          if (pj_tv && line_q && beat != LAST_BEAT) begin
            beat <= beat + 2'd1;
          end else begin
            state <= ST_IDLE;
            beat  <= 2'd0;
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RESP acks beat k while already fetching beat k+1, so the
  // SRAM word offset runs one ahead of the ack counter there.
  assign issue = (state == ST_ACC)
              || (state == ST_RESP && line_q
                  && beat != LAST_BEAT);

  assign word_off  = (state == ST_RESP) ? beat + 2'd1 : beat;
  assign word_lo   = addr_q[1:0] + word_off;
  assign word_addr = {addr_q[MEM_AW-1:2], word_lo};

  assign mem_cs    = issue;
  assign mem_we    = (state == ST_ACC) && write_q;
  assign mem_be    = issue ? be_q : 4'd0;
  assign mem_addr  = issue ? word_addr : '0;
  assign mem_wdata = mem_we ? wdata_q : 32'd0;

  always_comb begin
    pj_ack = ACK_NONE;
    if (state == ST_RESP) pj_ack = ACK_OK;
    if (state == ST_ERR)  pj_ack = ACK_ERR;
  end

  assign pj_data_in = (state == ST_RESP && !write_q)
                    ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_pj_mem_slave.sv
// Scoreboard bench for pj_mem_slave with W=0 and W=1 instances.
// Expected acks and SRAM accesses are queued at drive time.
module tb_pj_mem_slave;
  import pj_bus_pkg::*;

  localparam int AW = 16;

  typedef struct {
    int          cyc;
    logic [1:0]  code;
    logic [31:0] data;
  } ack_e;

  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  be;
    int          addr;
    logic [31:0] wdata;
  } mem_e;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [29:0]   pj_addr;
  logic [31:0]   pj_data_out;
  logic          pj_tv;
  logic          pj_ale;
  logic [3:0]    pj_type;
  logic [1:0]    pj_size;
  logic          sel;
  logic [31:0]   mem_rdata;

  logic [1:0]    ack0, ack1, ack_m;
  logic [31:0]   din0, din1, din_m;
  logic          cs0, cs1, cs_m;
  logic          we0, we1, we_m;
  logic [3:0]    be0, be1, be_m;
  logic [AW-1:0] ad0, ad1, ad_m;
  logic [31:0]   wd0, wd1, wd_m;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  ack_e          ackq[$];
  mem_e          memq[$];
  logic [31:0]   ref_mem [int];
  logic [31:0]   sram [0:(1<<AW)-1];
  ack_e          mon_a;
  mem_e          mon_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pj_mem_slave #(.MEM_AW(AW), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .pj_addr(pj_addr), .pj_data_out(pj_data_out),
    .pj_tv(pj_tv & ~sel), .pj_ale(pj_ale & ~sel),
    .pj_type(pj_type), .pj_size(pj_size),
    .pj_ack(ack0), .pj_data_in(din0),
    .mem_cs(cs0), .mem_we(we0), .mem_be(be0),
    .mem_addr(ad0), .mem_wdata(wd0),
    .mem_rdata(mem_rdata)
  );

  pj_mem_slave #(.MEM_AW(AW), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset),
    .pj_addr(pj_addr), .pj_data_out(pj_data_out),
    .pj_tv(pj_tv & sel), .pj_ale(pj_ale & sel),
    .pj_type(pj_type), .pj_size(pj_size),
    .pj_ack(ack1), .pj_data_in(din1),
    .mem_cs(cs1), .mem_we(we1), .mem_be(be1),
    .mem_addr(ad1), .mem_wdata(wd1),
    .mem_rdata(mem_rdata)
  );

  assign ack_m = sel ? ack1 : ack0;
  assign din_m = sel ? din1 : din0;
  assign cs_m  = sel ? cs1 : cs0;
  assign we_m  = sel ? we1 : we0;
  assign be_m  = sel ? be1 : be0;
  assign ad_m  = sel ? ad1 : ad0;
  assign wd_m  = sel ? wd1 : wd0;

  always @(posedge clk) begin
    if (cs_m) begin
      if (we_m) begin
        for (int b = 0; b < 4; b++)
          if (be_m[b]) sram[ad_m][b*8 +: 8] <= wd_m[b*8 +: 8];
      end else begin
        mem_rdata <= sram[ad_m];
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ack_m != ACK_NONE) begin
        if (ackq.size() == 0) begin
          check("ack_unexpected", 32'(ack_m), 32'(ACK_NONE));
        end else begin
          mon_a = ackq.pop_front();
          check("ack_cycle", cyc, mon_a.cyc);
          check("ack_code", 32'(ack_m), 32'(mon_a.code));
          check("ack_data", din_m, mon_a.data);
        end
      end else if (din_m != 32'd0) begin
        check("data_idle", din_m, 32'd0);
      end
      if (cs_m) begin
        if (memq.size() == 0) begin
          check("cs_unexpected", 32'(cs_m), 32'd0);
        end else begin
          mon_m = memq.pop_front();
          check("cs_cycle", cyc, mon_m.cyc);
          check("mem_we", 32'(we_m), 32'(mon_m.we));
          check("mem_be", 32'(be_m), 32'(mon_m.be));
          check("mem_addr", 32'(ad_m), mon_m.addr);
          check("mem_wdata", wd_m, mon_m.wdata);
        end
      end else if (we_m || be_m != 0 || ad_m != 0 || wd_m != 0) begin
        check("mem_idle", {we_m, be_m, wd_m[26:0]}, 32'd0);
      end
      if (sel ? cs0 : cs1) check("cs_other", 32'd1, 32'd0);
    end
  end

  // stop: 0 runs to completion; otherwise end after that many acks,
  // by dropping pj_tv (rst=0) or by asserting reset one cycle later.
  task automatic txn(input logic [29:0] a, input logic [3:0] t,
                     input logic [1:0] s, input logic [31:0] d,
                     input bit err, input int stop, input bit rst);
    int c, w, n, last, wa;
    logic [3:0] be;
    logic [31:0] v;
    c = cyc;
    w = sel ? 1 : 0;
    pj_addr = a; pj_type = t; pj_size = s; pj_data_out = d;
    pj_tv = 1'b1; pj_ale = 1'b1;
    if (err) begin
      ackq.push_back('{c + 1, ACK_ERR, 32'd0});
      last = c + 1;
    end else begin
      n = (t == TYPE_LINE) ? 4 : 1;
      case (s)
        SIZE_BYTE: be = 4'b1000 >> a[1:0];
        SIZE_HALF: be = a[1] ? 4'b0011 : 4'b1100;
        default:   be = 4'b1111;
      endcase
      for (int k = 0; k < n; k++) begin
        wa = (int'(a[17:4]) << 2) | ((int'(a[3:2]) + k) % 4);
        if (stop == 0 || k <= stop)
          memq.push_back('{c + w + 1 + k, t == TYPE_WR, be, wa,
                           (t == TYPE_WR) ? d : 32'd0});
        if (t == TYPE_WR) begin
          v = ref_mem.exists(wa) ? ref_mem[wa] : 32'd0;
          for (int b = 0; b < 4; b++)
            if (be[b]) v[b*8 +: 8] = d[b*8 +: 8];
          ref_mem[wa] = v;
          v = 32'd0;
        end else begin
          v = ref_mem.exists(wa) ? ref_mem[wa] : 32'd0;
        end
        if (stop == 0 || k < stop)
          ackq.push_back('{c + w + 2 + k, ACK_OK, v});
      end
      last = c + w + 1 + ((stop > 0) ? stop : n);
    end
    @(posedge clk); #1;
    pj_ale = 1'b0;
    if (stop > 0 && !err && !rst) begin
      repeat (last - c - 1) @(posedge clk); #1;
      pj_tv = 1'b0;
    end else begin
      repeat (last - c) @(posedge clk); #1;
      if (rst) reset = 1'b1;
      pj_tv = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, {28'd0, ack0, ack1}, 32'd0);
    check({tag, "_din"}, din0 | din1, 32'd0);
    check({tag, "_cs_we"}, {28'd0, cs0, cs1, we0, we1}, 32'd0);
    check({tag, "_be"}, {24'd0, be0, be1}, 32'd0);
    check({tag, "_addr"}, {ad0, ad1}, 32'd0);
    check({tag, "_wdata"}, wd0 | wd1, 32'd0);
  endtask

  initial begin
    pj_tv = 1'b0; pj_ale = 1'b0; pj_addr = '0;
    pj_type = '0; pj_size = '0; pj_data_out = '0;
    sel = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    txn(30'h10,  TYPE_WR, SIZE_WORD, 32'h40404040, 0, 0, 0);
    txn(30'h14,  TYPE_WR, SIZE_WORD, 32'hCAFEBABE, 0, 0, 0);
    txn(30'h18,  TYPE_WR, SIZE_WORD, 32'h60606060, 0, 0, 0);
    txn(30'h1C,  TYPE_WR, SIZE_WORD, 32'h70707070, 0, 0, 0);
    txn(30'h100, TYPE_WR, SIZE_WORD, 32'h11223344, 0, 0, 0);

    txn(30'h14,  TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);
    txn(30'h103, TYPE_WR, SIZE_BYTE, 32'h000000AA, 0, 0, 0);
    txn(30'h100, TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);
    txn(30'h102, TYPE_WR, SIZE_HALF, 32'h0000BEEF, 0, 0, 0);
    txn(30'h101, TYPE_RD, SIZE_BYTE, 32'h0, 0, 0, 0);
    txn(30'h1C,  TYPE_LINE, SIZE_WORD, 32'h0, 0, 0, 0);

    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      txn(30'h3000_0000, TYPE_RD, SIZE_WORD, 32'h0, 1, 0, 0);
      txn(30'h1, TYPE_RD, SIZE_HALF, 32'h0, 1, 0, 0);
      txn(30'h10, 4'b0101, SIZE_WORD, 32'h0, 1, 0, 0);
      txn(30'h10, TYPE_RD, SIZE_BAD, 32'h0, 1, 0, 0);
      txn(30'h10, TYPE_LINE, SIZE_HALF, 32'h0, 1, 0, 0);
    end

    sel = 1'b0;
    txn(30'h18, TYPE_LINE, SIZE_WORD, 32'h0, 0, 0, 0);
    txn(30'h103, TYPE_WR, SIZE_BYTE, 32'h00000055, 0, 0, 0);
    txn(30'h100, TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);

    txn(30'h18, TYPE_LINE, SIZE_WORD, 32'h0, 0, 2, 0);
    repeat (2) @(posedge clk); #1;
    txn(30'h14, TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);

    txn(30'h18, TYPE_LINE, SIZE_WORD, 32'h0, 0, 2, 1);
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn(30'h14, TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);
    sel = 1'b1;
    txn(30'h18, TYPE_RD, SIZE_WORD, 32'h0, 0, 0, 0);

    repeat (4) @(posedge clk); #1;
    check("ack_queue_empty", ackq.size(), 32'd0);
    check("mem_queue_empty", memq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
